// File: rtl/hdc_pkg.sv
// hdc_pkg: shared constants, types and FSM states for the HDC associative memory
package hdc_pkg;
  localparam int NUM_VALS    = 10000;
  localparam int CHUNK       = 500;
  localparam int NUM_CLASSES = 2;
  localparam int NUM_CHUNKS  = NUM_VALS / CHUNK;
  localparam int DIST_W      = $clog2(NUM_VALS + 1);
  localparam int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int IDX_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PC_W        = $clog2(CHUNK + 1);
  typedef logic [NUM_VALS-1:0] hv_t;
  typedef logic [DIST_W-1:0] dist_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, COMPARE, DONE} am_state_t;
endpackage

// File: rtl/hv_popcount.sv
// hv_popcount: combinational popcount built as a recursive balanced adder tree
module hv_popcount #(
  parameter int WIDTH = hdc_pkg::CHUNK
) (
  input  logic [WIDTH-1:0]             bits_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);
  localparam int OW = $clog2(WIDTH + 1);
  generate
    if (WIDTH == 1) begin : g_leaf
      assign count_o = bits_i;
    end else begin : g_split
      localparam int LW = WIDTH / 2;
      localparam int HW = WIDTH - LW;
      logic [$clog2(LW+1)-1:0] lo;
      logic [$clog2(HW+1)-1:0] hi;
      hv_popcount #(.WIDTH(LW)) u_lo (.bits_i(bits_i[LW-1:0]),     .count_o(lo));
      hv_popcount #(.WIDTH(HW)) u_hi (.bits_i(bits_i[WIDTH-1:LW]), .count_o(hi));
      assign count_o = OW'(lo) + OW'(hi);
    end
  endgenerate
endmodule

// File: rtl/hdc_assoc_mem.sv
// hdc_assoc_mem: chunked minimum-Hamming-distance classifier of a query against class prototypes
module hdc_assoc_mem
  import hdc_pkg::*;
(
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_VALS-1:0]             query_hv,
  input  logic [NUM_CLASSES*NUM_VALS-1:0] class_hvs,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CLS_W-1:0]                class_out,
  output logic [DIST_W-1:0]               min_dist
);
  am_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  dist_t            acc_q [NUM_CLASSES];
  dist_t            acc_d [NUM_CLASSES];
  hv_t              query_q, query_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  dist_t            dist_q, dist_d;
  logic [PC_W-1:0]  pc [NUM_CLASSES];
  logic [CLS_W-1:0] best_c;
  dist_t            best_d;
  // class_hvs is read live; it must stay stable until the result is out
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
    hv_popcount #(.WIDTH(CHUNK)) u_pc (
      .bits_i (query_q[idx_q*CHUNK +: CHUNK] ^ class_hvs[k*NUM_VALS + idx_q*CHUNK +: CHUNK]),
      .count_o(pc[k])
    );
  end
  // strict less-than keeps the lowest index on ties
  always_comb begin
    best_c = '0;
    best_d = acc_q[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (acc_q[k] < best_d) begin
        best_d = acc_q[k];
        best_c = CLS_W'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    query_d = query_q;
    cls_d   = cls_q;
    dist_d  = dist_q;
    case (state_q)
      IDLE: if (in_valid) begin
        query_d = query_hv;
        idx_d   = '0;
        for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = acc_q[k] + DIST_W'(pc[k]);
        idx_d   = (idx_q == IDX_W'(NUM_CHUNKS - 1)) ? '0 : idx_q + 1'b1;
        state_d = (idx_q == IDX_W'(NUM_CHUNKS - 1)) ? COMPARE : COMPUTE;
      end
      COMPARE: begin
        cls_d   = best_c;
        dist_d  = best_d;
        state_d = DONE;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
      query_q <= '0;
      cls_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      query_q <= query_d;
      cls_q   <= cls_d;
      dist_q  <= dist_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign class_out = cls_q;
  assign min_dist  = dist_q;
endmodule

// File: tb/tb_hdc_assoc_mem.sv
// tb_hdc_assoc_mem: directed plus randomized checks of hdc_assoc_mem against a Hamming-distance model
module tb_hdc_assoc_mem;
  import hdc_pkg::*;
  logic                            clk = 1'b0;
  logic                            nrst = 1'b0;
  logic                            in_valid = 1'b0;
  logic                            in_ready;
  hv_t                             query_hv = '0;
  logic [NUM_CLASSES*NUM_VALS-1:0] class_hvs = '0;
  logic                            out_valid;
  logic                            out_ready = 1'b0;
  logic [CLS_W-1:0]                class_out;
  logic [DIST_W-1:0]               min_dist;
  int vectors = 0;
  int miscompares = 0;
  hv_t a, q, c0, c1;
  always #5 clk = ~clk;
  hdc_assoc_mem dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .query_hv(query_hv), .class_hvs(class_hvs), .out_valid(out_valid),
    .out_ready(out_ready), .class_out(class_out), .min_dist(min_dist)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int ham(input hv_t x, input hv_t y);
    int d = 0;
    for (int i = 0; i < NUM_VALS; i++) d += (x[i] != y[i]) ? 1 : 0;
    return d;
  endfunction
  function automatic hv_t rand_hv();
    hv_t v;
    for (int i = 0; i < NUM_VALS; i++) v[i] = 1'($urandom);
    return v;
  endfunction
  task automatic send(input hv_t qv);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 1);
    query_hv = qv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    query_hv = rand_hv();
  endtask
  task automatic run(input string tag, input hv_t qv, input hv_t k0, input hv_t k1, input int hold);
    int n = 0;
    int d0 = ham(qv, k0);
    int d1 = ham(qv, k1);
    int ec = (d1 < d0) ? 1 : 0;
    int ed = (d1 < d0) ? d1 : d0;
    class_hvs = {k1, k0};
    send(qv);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, 32'(n), NUM_CHUNKS + 1);
    check({tag, "_class"}, 32'(class_out), 32'(ec));
    check({tag, "_dist"}, 32'(min_dist), 32'(ed));
    check({tag, "_in_ready_done"}, 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_class"}, 32'(class_out), 32'(ec));
      check({tag, "_hold_dist"}, 32'(min_dist), 32'(ed));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 1);
  endtask
  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_class", 32'(class_out), 0);
    check("rst_dist", 32'(min_dist), 0);
    #20 nrst = 1'b1;
    a = rand_hv();
    run("exact", a, a, ~a, 0);
    run("inverse", ~a, a, ~a, 0);
    q = a;
    q[0] = ~q[0];
    q[4999] = ~q[4999];
    q[9999] = ~q[9999];
    run("near", q, a, ~a, 0);
    q = a;
    for (int j = 0; j < 7; j++) q[j*1400 + $urandom_range(0, 1399)] ^= 1'b1;
    run("tie", q, a, a, 0);
    q = ~a;
    q[500] = ~q[500];
    run("backpressure", q, a, ~a, 5);
    for (int r = 0; r < 4; r++) begin
      c0 = rand_hv();
      c1 = rand_hv();
      run("random", rand_hv(), c0, c1, $urandom_range(0, 2));
    end
    // leave a nonzero result registered so the reset check is meaningful
    run("pre_reset", ~a, a, ~a, 0);
    class_hvs = {~a, a};
    send(a);
    repeat (9) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_class", 32'(class_out), 0);
    check("midrst_dist", 32'(min_dist), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk) nrst = 1'b1;
    run("post_reset", a, a, ~a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hdc_assoc_mem.md
Name: hdc_assoc_mem

Overview:
- Read-side counterpart of the hypervector generator: consumes a NUM_VALS-bit query hypervector and classifies it against NUM_CLASSES class prototypes.
- Classification uses minimum Hamming distance.
- Processes CHUNK bits per cycle with a per-class accumulator, so area stays bounded at D=10000.
- Sits at the end of the seizure-detection datapath. Its class index drives the seizure / non-seizure decision.

Parameters:
- NUM_VALS, 10000: hypervector dimension in bits.
- NUM_CLASSES, 2: number of class prototypes (0 = non-seizure, 1 = seizure).
- CHUNK, 500: bits compared per cycle. NUM_VALS must be an exact multiple of CHUNK.
- DIST_W, $clog2(NUM_VALS+1): width of a Hamming distance.
- CLS_W, $clog2(NUM_CLASSES) (minimum 1): width of a class index.

Ports:
- clk, input, 1: single clock, rising edge.
- nrst, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: query_hv is valid.
- in_ready, output, 1: block is idle and can accept a query.
- query_hv, input, NUM_VALS: query hypervector. Sampled on acceptance.
- class_hvs, input, NUM_CLASSES*NUM_VALS: prototypes. Class k occupies bits [k*NUM_VALS +: NUM_VALS].
- out_valid, output, 1: result is valid.
- out_ready, input, 1: downstream accepts the result.
- class_out, output, CLS_W: index of the closest class.
- min_dist, output, DIST_W: Hamming distance to the closest class.

Behaviour:
- Reset values while nrst=0, applied asynchronously:
  - state=IDLE, in_ready=1, out_valid=0, class_out=0, min_dist=0.
  - Chunk counter and all accumulators = 0.
  - Query register = 0.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: latch query_hv, clear accumulators, set chunk index to 0, go to COMPUTE.
- COMPUTE:
  - in_ready=0.
  - Each cycle, for every class k: acc[k] += popcount(query[idx*CHUNK +: CHUNK] ^ class_k[idx*CHUNK +: CHUNK]).
  - Then idx++.
  - After chunk NUM_VALS/CHUNK-1, go to COMPARE.
- COMPARE (one cycle):
  - Sequential scan over k = 0 to NUM_CLASSES-1. Strictly-less comparison, so ties go to the lowest index.
  - Register class_out and min_dist. Go to DONE with out_valid=1.
- DONE:
  - out_valid, class_out and min_dist are held stable until out_valid & out_ready.
  - On that handshake: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap between results and the next query.
- Latency: out_valid rises NUM_VALS/CHUNK+1 rising edges after the accepting edge (21 at defaults). Best-case throughput is one query per NUM_VALS/CHUNK+3 cycles.
- class_hvs must be stable from acceptance until out_valid. It is read live during COMPUTE and is not latched.
- Accumulators are DIST_W bits wide. Overflow is impossible because the maximum distance is NUM_VALS.
- in_valid while in_ready=0 is ignored. The query is not consumed.
- Reset mid-operation: an immediate return to the reset values. No partial result is emitted.
- With NUM_CLASSES=1: class_out is always 0 and min_dist is that class's distance.

Decomposition:
- Package hdc_pkg holds:
  - Constants NUM_VALS, CHUNK, NUM_CLASSES, DIST_W, CLS_W, NUM_CHUNKS.
  - typedef hv_t (logic [NUM_VALS-1:0]).
  - typedef dist_t.
  - Enum am_state_t {IDLE, COMPUTE, COMPARE, DONE}.
- One sub-module, hv_popcount: combinational adder-tree popcount.
  - Parameter WIDTH=CHUNK, output width $clog2(WIDTH+1).
  - Instantiated NUM_CLASSES times.

Test Plan:
- Exact match: class0 = random A, class1 = ~A, query = A -> out_valid 21 cycles after accept, class_out=0, min_dist=0.
- Inverse match: same prototypes, query = ~A -> class_out=1, min_dist=0. The distance to class 0 is 10000; check that no accumulator wraps.
- Near match: query = A with bits 0, 4999 and 9999 flipped -> class_out=0, min_dist=3. The chunk-boundary bit positions confirm correct chunk indexing.
- Tie: class0 = class1 = A, query = A with 7 bits flipped -> class_out=0, min_dist=7.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Raise out_ready -> out_valid drops the next cycle and in_ready returns to 1.
- Reset mid-compute: drop nrst 10 cycles after accept -> out_valid=0, class_out=0, min_dist=0 immediately. After release, in_ready=1, and a new exact-match query completes correctly in 21 cycles.
